button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
Input-conditioning stage that sits directly upstream of the stopwatch top-level control FSM. It takes raw, bouncing push-button and switch inputs (start, stop, countUp, ...) from the board pins. It produces per channel:
- clean, synchronized, debounced levels;
- single-clock press and release pulses;
- a one-shot long-press pulse.
All logic runs on the single board clock; there are no derived clocks.

Parameters:
N_BTN, 3, number of independent input channels
CNT_MAX, 500000, consecutive stable clocks required to accept a level change (5 ms at 100 MHz); must be >= 2
HOLD_MAX, 100000000, clocks a debounced level must stay high before btn_hold fires (1 s at 100 MHz); 0 disables hold detection
CNT_W, clog2(CNT_MAX+1), debounce counter width (derived; not overridden)
HOLD_W, clog2(HOLD_MAX+1), hold counter width (derived; not overridden)

Ports:
clk  input  1  board clock; all state on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
btn_raw  input  N_BTN  raw asynchronous pin levels, 1 = pressed
btn_level  output  N_BTN  debounced level per channel
btn_press  output  N_BTN  one-clock pulse on debounced 0->1
btn_release  output  N_BTN  one-clock pulse on debounced 1->0
btn_hold  output  N_BTN  one-clock pulse when level has been high for HOLD_MAX clocks

Behaviour:
- Reset (async, active-high): synchronizer flops, debounce counters, hold counters, btn_level, btn_press, btn_release and btn_hold all go to 0. No pulses are emitted while reset is asserted.
- Synchronizer: a 2-flop chain per channel (sync1 -> sync2). Only sync2 is used downstream.
- Debounce, per channel:
  - If sync2 == btn_level, the counter clears to 0.
  - If sync2 != btn_level and counter < CNT_MAX-1, the counter increments.
  - If sync2 != btn_level and counter == CNT_MAX-1, btn_level toggles and the counter clears.
  - Any single-clock agreement during counting restarts the count from 0. A glitch shorter than CNT_MAX clocks is never passed through.
- Latency: a clean raw edge appears on btn_level exactly CNT_MAX+2 clocks later (2 synchronizer + CNT_MAX debounce).
- Press/release: registered outputs, asserted on the same edge btn_level changes, high for exactly one clock.
  - btn_press asserts on a 0->1 change; btn_release on a 1->0 change.
  - They are never asserted together on the same channel.
- Hold, per channel (HOLD_MAX > 0):
  - The hold counter clears while btn_level == 0.
  - While btn_level == 1 it increments, saturating at HOLD_MAX.
  - btn_hold pulses for one clock on the edge the counter reaches HOLD_MAX, i.e. HOLD_MAX clocks after btn_press.
  - It fires at most once per press.
  - Release before reaching HOLD_MAX gives no btn_hold.
  - With HOLD_MAX == 0, btn_hold is tied to 0 and no hold counter is built.
- Channel independence: channels share no state. Simultaneous events on several channels produce simultaneous pulses.
- Reset mid-operation:
  - Counters abort and no pulse is emitted.
  - If btn_raw is held high through reset, after deassertion btn_level rises after CNT_MAX+2 clocks and btn_press fires. A held button counts as a fresh press.
- Width rules: counters are unsigned. The debounce counter never exceeds CNT_MAX-1; the hold counter never exceeds HOLD_MAX. There is no wrap-around.

Decomposition:
- Shared package (stopwatch_pkg):
  - CLK_FREQ_HZ = 100000000;
  - DEBOUNCE_MS = 5 and derived DEBOUNCE_CNT;
  - HOLD_CNT for 1 s;
  - channel index constants BTN_START = 0, BTN_STOP = 1, BTN_MODE = 2.
- Sub-module debounce_channel: one instance per channel via a generate loop. It contains the synchronizer, the debounce counter, the level/press/release registers and the hold counter. button_conditioner is the generate wrapper plus output concatenation.

Test Plan (sim with CNT_MAX=4, HOLD_MAX=10, N_BTN=3):
- Reset released, btn_raw=000 for 20 clks -> all outputs 0, no pulses.
- btn_raw[0] 0->1 and held -> btn_level[0]=1 and btn_press[0]=1 for one clk exactly 6 clks after the edge; btn_release and btn_hold stay 0 until the hold point.
- Continue holding ch0 -> btn_hold[0] pulses once, 10 clks after btn_press[0]; no second pulse over a further 30 clks. Release -> btn_release[0] pulses 6 clks after the falling edge.
- Bounce ch1: raw 1 for 3 clks, 0 for 1 clk, 1 for 3 clks, then 0 -> btn_level[1] never rises; no press, release or hold pulses.
- Simultaneous raw rise on ch0 and ch2 -> btn_press[0] and btn_press[2] on the same clock; ch1 unaffected.
- Hold raw ch2=1, assert reset mid-count for 3 clks, then release -> outputs 0 during reset; btn_press[2] fires 6 clks after reset deasserts. Release ch2 3 clks after press -> btn_release[2] pulses, and no btn_hold[2].

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch constants: board clock, debounce/hold timing and button channel indices.
package stopwatch_pkg;

  localparam int unsigned CLK_FREQ_HZ  = 100_000_000;
  localparam int unsigned DEBOUNCE_MS  = 5;
  localparam int unsigned DEBOUNCE_CNT = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;
  localparam int unsigned HOLD_CNT     = CLK_FREQ_HZ;

  localparam int unsigned BTN_START = 0;
  localparam int unsigned BTN_STOP  = 1;
  localparam int unsigned BTN_MODE  = 2;
  localparam int unsigned N_BTN_STD = BTN_MODE + 1;

  // Counter width able to hold 0..max_val; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, debounce counter, edge pulses and long-press detect.
module debounce_channel
  import stopwatch_pkg::*;
#(
  parameter int unsigned CNT_MAX  = DEBOUNCE_CNT,
  parameter int unsigned HOLD_MAX = HOLD_CNT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic hold_o
);

  localparam int unsigned      CNT_W    = cnt_width(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= raw_i;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Any cycle where the synchronized input agrees with the level restarts the count.
  always_comb begin
    cnt_d     = '0;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d   = ~level_q;
        press_d   = ~level_q;
        release_d = level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

  if (HOLD_MAX > 0) begin : g_hold
    localparam int unsigned       HOLD_W    = cnt_width(HOLD_MAX);
    localparam logic [HOLD_W-1:0] HOLD_TOP  = HOLD_W'(HOLD_MAX);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(HOLD_MAX - 1);

    logic [HOLD_W-1:0] hcnt_q, hcnt_d;
    logic              hold_q, hold_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        hcnt_q <= '0;
        hold_q <= 1'b0;
      end else begin
        hcnt_q <= hcnt_d;
        hold_q <= hold_d;
      end
    end

    // Saturation at HOLD_TOP keeps the pulse to one per press.
    always_comb begin
      hcnt_d = '0;
      hold_d = 1'b0;
      if (level_q) begin
        hcnt_d = (hcnt_q == HOLD_TOP) ? hcnt_q : hcnt_q + 1'b1;
        hold_d = (hcnt_q == HOLD_FIRE);
      end
    end

    assign hold_o = hold_q;
  end else begin : g_no_hold
    assign hold_o = 1'b0;
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions raw board buttons into debounced levels plus press/release/long-press pulses.
module button_conditioner
  import stopwatch_pkg::*;
#(
  parameter int unsigned N_BTN    = N_BTN_STD,
  parameter int unsigned CNT_MAX  = DEBOUNCE_CNT,
  parameter int unsigned HOLD_MAX = HOLD_CNT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_hold
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_channel #(
      .CNT_MAX  (CNT_MAX),
      .HOLD_MAX (HOLD_MAX)
    ) u_ch (
      .clk_i     (clk),
      .rst_i     (reset),
      .raw_i     (btn_raw[i]),
      .level_o   (btn_level[i]),
      .press_o   (btn_press[i]),
      .release_o (btn_release[i]),
      .hold_o    (btn_hold[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: stimulus queues expected pulse events, a negedge monitor pops and checks them.
module tb_button_conditioner;

  localparam int unsigned N   = 3;
  localparam int unsigned CM  = 4;
  localparam int unsigned HM  = 10;
  localparam int unsigned LAT = CM + 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_hold;

  typedef struct packed {
    int unsigned  cyc;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] hold;
    logic [N-1:0] level;
  } ev_t;

  ev_t         sb[$];
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  button_conditioner #(
    .N_BTN    (N),
    .CNT_MAX  (CM),
    .HOLD_MAX (HM)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_hold    (btn_hold)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int unsigned c, input logic [N-1:0] p, input logic [N-1:0] r,
                      input logic [N-1:0] h, input logic [N-1:0] l);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.hold = h; e.level = l;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (sb.size() != 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      chk("overdue_event_cycle", cyc, e.cyc);
    end
    if ((btn_press | btn_release | btn_hold) != '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {btn_press, btn_release, btn_hold}, 0);
      end else begin
        e = sb.pop_front();
        chk("event_cycle", cyc, e.cyc);
        chk("btn_press", btn_press, e.press);
        chk("btn_release", btn_release, e.rel);
        chk("btn_hold", btn_hold, e.hold);
        chk("btn_level", btn_level, e.level);
      end
    end
  end

  initial begin
    int unsigned c;
    int unsigned r;

    // Reset asserted: everything low.
    repeat (3) @(negedge clk);
    chk("outputs_in_reset", {btn_level, btn_press, btn_release, btn_hold}, 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("outputs_idle", {btn_level, btn_press, btn_release, btn_hold}, 0);

    // Channel 0 press, long hold, release.
    c = cyc;
    btn_raw[0] = 1'b1;
    push(c + LAT, 3'b001, 3'b000, 3'b000, 3'b001);
    push(c + LAT + HM, 3'b000, 3'b000, 3'b001, 3'b001);
    wait_cyc(c + LAT - 1);
    chk("level0_before_latency", btn_level, 0);
    wait_cyc(c + LAT + HM + 30);
    chk("level0_held", btn_level, 3'b001);
    c = cyc;
    btn_raw[0] = 1'b0;
    push(c + LAT, 3'b000, 3'b001, 3'b000, 3'b000);
    wait_cyc(c + LAT + 10);

    // Channel 1 bounce: runs of 3 never reach the 4-clock threshold.
    btn_raw[1] = 1'b1; repeat (3) @(negedge clk);
    btn_raw[1] = 1'b0; repeat (1) @(negedge clk);
    btn_raw[1] = 1'b1; repeat (3) @(negedge clk);
    btn_raw[1] = 1'b0;
    repeat (20) @(negedge clk);
    chk("level_after_bounce", btn_level, 0);

    // Simultaneous channels 0 and 2.
    c = cyc;
    btn_raw = 3'b101;
    push(c + LAT, 3'b101, 3'b000, 3'b000, 3'b101);
    push(c + LAT + HM, 3'b000, 3'b000, 3'b101, 3'b101);
    wait_cyc(c + 20);
    chk("level_dual", btn_level, 3'b101);
    c = cyc;
    btn_raw = 3'b000;
    push(c + LAT, 3'b000, 3'b101, 3'b000, 3'b000);
    wait_cyc(c + LAT + 10);

    // Channel 2 held through a mid-count reset, then short press.
    btn_raw[2] = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("outputs_mid_reset", {btn_level, btn_press, btn_release, btn_hold}, 0);
    repeat (3) @(negedge clk);
    r = cyc;
    reset = 1'b0;
    push(r + LAT, 3'b100, 3'b000, 3'b000, 3'b100);
    push(r + LAT + 3 + LAT, 3'b000, 3'b100, 3'b000, 3'b000);
    wait_cyc(r + LAT + 3);
    btn_raw[2] = 1'b0;
    wait_cyc(r + LAT + 3 + LAT + HM + 10);
    chk("level_final", btn_level, 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
